// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// shared-ALU arbiter/sequencer.
package alu_share_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Opcodes 110 and 111 have no ALU function and are flagged as errors.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op >= 3'b110);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Shared 4-bit ALU datapath: add/sub with carry and signed overflow,
// bitwise and/or/xor, and low nibble of the product. Illegal opcodes
// produce an all-zero result.
module TOP_fourbit_ALU
  import alu_share_ctrl_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] out,
  output logic       cout,
  output logic       v
);

  logic        [3:0] b_eff;
  logic        [4:0] sum;
  logic        [3:0] prod;
  logic signed [3:0] a_s;
  logic signed [3:0] b_eff_s;
  logic signed [3:0] sum_s;

  // Adder/subtractor shares one carry chain; subtract is a + ~b + 1.
  always_comb begin
    b_eff   = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sub};
    prod    = a * b;
    a_s     = a;
    b_eff_s = b_eff;
    sum_s   = sum[3:0];
    out     = 4'b0000;
    cout    = 1'b0;
    v       = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        out  = sum[3:0];
        cout = sum[4];
        // Signed overflow: equal operand signs into the adder, differing result sign.
        v    = (a_s[3] == b_eff_s[3]) && (sum_s[3] != a_s[3]);
      end
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_MUL:  out = prod;
      default: out = 4'b0000;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin arbiter and 3-state sequencer around one shared
// 4-bit ALU. One command is in flight at a time; the tagged response is held
// until the consumer accepts it, and completions are counted per requester.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_opcode,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_opcode,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_out,
  output logic             rsp_cout,
  output logic             rsp_v,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  state_t     state;
  logic       rr_last;
  logic [2:0] op_p0;
  logic [3:0] a_p0;
  logic [3:0] b_p0;
  logic       id_p0;
  logic       grant0;
  logic       grant1;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic       alu_v;

  // Completion counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Round-robin grant: the requester not served last wins a tie.
  always_comb begin
    grant0 = (state == ST_IDLE) && req0_valid && (!req1_valid || rr_last);
    grant1 = (state == ST_IDLE) && req1_valid && (!req0_valid || !rr_last);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != ST_IDLE);

  TOP_fourbit_ALU u_alu (
    .op   (op_p0),
    .a    (a_p0),
    .b    (b_p0),
    .sub  (op_p0 == OP_SUB),
    .out  (alu_out),
    .cout (alu_cout),
    .v    (alu_v)
  );

  // Sequencer: capture on grant, execute for one cycle, hold response until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_last   <= 1'b1;
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= '0;
      rsp_cout  <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_err   <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      case (state)
        // Stage p0: command capture
        ST_IDLE: begin
          if (grant0 || grant1) begin
            op_p0   <= grant1 ? req1_opcode : req0_opcode;
            a_p0    <= grant1 ? req1_a      : req0_a;
            b_p0    <= grant1 ? req1_b      : req0_b;
            id_p0   <= grant1;
            rr_last <= grant1;
            state   <= ST_EXEC;
          end
        end
        // Stage p1: ALU result registered into the response
        ST_EXEC: begin
          rsp_out   <= alu_out;
          rsp_cout  <= alu_cout;
          rsp_v     <= alu_v;
          rsp_err   <= op_illegal(op_p0);
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
            if (rsp_id) cnt1 <= sat_inc(cnt1);
            else        cnt0 <= sat_inc(cnt0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: table of hand-computed commands, streaming and
// reset corner sequences, and a cycle model with a response scoreboard.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_opcode, req1_opcode;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_ready;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_v, rsp_err, busy;
  logic [3:0] rsp_out;
  logic [7:0] cnt0, cnt1;

  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_cout, s_rsp_v, s_rsp_err, s_busy;
  logic [3:0] s_rsp_out;
  logic [1:0] s_cnt0, s_cnt1;

  alu_share_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_cout(rsp_cout), .rsp_v(rsp_v), .rsp_err(rsp_err), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_share_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_out(s_rsp_out),
    .rsp_cout(s_rsp_cout), .rsp_v(s_rsp_v), .rsp_err(s_rsp_err), .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU written in integer arithmetic; result packed as {id,out,cout,v,err}.
  function automatic logic [7:0] model(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, sr;
    logic [3:0] o;
    logic c, v, e;
    ua = int'(a); ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    o = 4'h0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      OP_ADD: begin r = ua + ub; sr = sa + sb; o = 4'(r); c = (r > 15); v = (sr > 7) || (sr < -8); end
      OP_SUB: begin r = ua - ub; sr = sa - sb; o = 4'(r); c = (ua >= ub); v = (sr > 7) || (sr < -8); end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_MUL: o = 4'(ua * ub);
      default: e = 1'b1;
    endcase
    return {id, o, c, v, e};
  endfunction

  // Cycle model and scoreboard
  logic [1:0] m_st;
  logic       m_rr;
  logic [7:0] m_c0, m_c1;
  logic [1:0] m_s0, m_s1;
  logic [7:0] sbq[$];
  logic       e0, e1;
  logic [7:0] sb_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 2'd0; m_rr = 1'b1; m_c0 = 8'd0; m_c1 = 8'd0; m_s0 = 2'd0; m_s1 = 2'd0;
      sbq.delete();
    end
    e0 = (m_st == 2'd0) && req0_valid && (!req1_valid || m_rr);
    e1 = (m_st == 2'd0) && req1_valid && (!req0_valid || !m_rr);
    check("ctl", 32'({req0_ready, req1_ready, rsp_valid, busy}), 32'({e0, e1, m_st == 2'd2, m_st != 2'd0}));
    check("ctl_w2", 32'({s_req0_ready, s_req1_ready, s_rsp_valid, s_busy}), 32'({e0, e1, m_st == 2'd2, m_st != 2'd0}));
    check("cnt", 32'({cnt1, cnt0}), 32'({m_c1, m_c0}));
    check("cnt_w2", 32'({s_cnt1, s_cnt0}), 32'({m_s1, m_s0}));
    if (rst_n) begin
      case (m_st)
        2'd0: if (e0 || e1) begin
          sbq.push_back(e1 ? model(1'b1, req1_opcode, req1_a, req1_b)
                           : model(1'b0, req0_opcode, req0_a, req0_b));
          m_rr = e1;
          m_st = 2'd1;
        end
        2'd1: m_st = 2'd2;
        2'd2: if (rsp_ready) begin
          if (sbq.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
          end else begin
            sb_exp = sbq.pop_front();
            check("rsp", 32'({rsp_id, rsp_out, rsp_cout, rsp_v, rsp_err}), 32'(sb_exp));
            check("rsp_w2", 32'({s_rsp_id, s_rsp_out, s_rsp_cout, s_rsp_v, s_rsp_err}), 32'(sb_exp));
            if (sb_exp[7]) begin
              m_c1 = (m_c1 == 8'hFF) ? m_c1 : m_c1 + 8'd1;
              m_s1 = (m_s1 == 2'd3) ? m_s1 : m_s1 + 2'd1;
            end else begin
              m_c0 = (m_c0 == 8'hFF) ? m_c0 : m_c0 + 8'd1;
              m_s0 = (m_s0 == 2'd3) ? m_s0 : m_s0 + 2'd1;
            end
          end
          m_st = 2'd0;
        end
        default: m_st = 2'd0;
      endcase
    end
  end

  typedef struct packed {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       cout;
    logic       v;
    logic       err;
  } vec_t;

  vec_t tbl[12];

  task automatic set_req(input logic id, input logic vld, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin req1_valid = vld; req1_opcode = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = vld; req0_opcode = op; req0_a = a; req0_b = b; end
  endtask

  // Issue one command, optionally stall the response for 'hold' cycles.
  task automatic do_cmd(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int hold, output logic [7:0] res);
    int n;
    logic rdy;
    logic [7:0] first;
    @(posedge clk); #1;
    set_req(id, 1'b1, op, a, b);
    rsp_ready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; rdy = id ? req1_ready : req0_ready; end while (!rdy && n < 20);
    if (!rdy) check("grant_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    if (!rsp_valid) check("rsp_timeout", 32'(0), 32'(1));
    first = {rsp_id, rsp_out, rsp_cout, rsp_v, rsp_err};
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (id) req0_valid = 1'b1; else req1_valid = 1'b1;
      end
      @(negedge clk);
      check("hold_stable", 32'({rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_v, rsp_err}), 32'({1'b1, first}));
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    res = first;
  endtask

  // Both requesters valid until each has been granted n_each times.
  task automatic stream(input int n_each,
                        input logic [2:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [2:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                        output int first_id, output int g0, output int g1);
    int cyc;
    logic id, last;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, op0, a0, b0);
    set_req(1'b1, 1'b1, op1, a1, b1);
    rsp_ready = 1'b1;
    g0 = 0; g1 = 0; first_id = -1; last = 1'b0; cyc = 0;
    while ((g0 < n_each || g1 < n_each) && cyc < 200) begin
      @(negedge clk); cyc++;
      if (req0_ready || req1_ready) begin
        id = req1_ready;
        if (first_id < 0) first_id = int'(id);
        else check("rr_alternate", 32'(id), 32'(!last));
        last = id;
        if (id) g1++; else g0++;
        @(posedge clk); #1;
        if (g0 >= n_each) req0_valid = 1'b0;
        if (g1 >= n_each) req1_valid = 1'b0;
      end
    end
    if (cyc >= 200) check("stream_timeout", 32'(0), 32'(1));
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (busy && cyc < 20);
    if (busy) check("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] res;
  int first_id, g0, g1, n;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_opcode = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_opcode = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
    rsp_ready = 1'b1;

    //          id    op      a     b     out   cout  v     err
    tbl[0]  = '{1'b0, OP_ADD, 4'h7, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, OP_AND, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, OP_OR,  4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, OP_XOR, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, OP_MUL, 4'h7, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, OP_SUB, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 3'b110, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'b111, 4'h3, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, OP_SUB, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, OP_MUL, 4'hF, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp", 32'({rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_v, rsp_err, busy}), 32'(0));
    check("reset_cnt", 32'({cnt1, cnt0}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_cmd(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, (i == 1) ? 4 : 0, res);
      check($sformatf("vec%0d", i), 32'(res),
            32'({tbl[i].id, tbl[i].out, tbl[i].cout, tbl[i].v, tbl[i].err}));
      if (i == 0) begin
        @(posedge clk); #1;
        check("cnt0_after_first", 32'(cnt0), 32'(1));
      end
    end
    @(posedge clk); #1;
    check("cnt_after_table", 32'({cnt1, cnt0}), 32'({8'd6, 8'd6}));

    stream(4, OP_ADD, 4'h7, 4'h1, OP_MUL, 4'h7, 4'h3, first_id, g0, g1);
    check("stream_grants", 32'({g0[7:0], g1[7:0]}), 32'({8'd4, 8'd4}));
    check("stream_cnt", 32'({cnt1, cnt0}), 32'({8'd10, 8'd10}));

    do_cmd(1'b0, 3'b110, 4'hF, 4'hF, 0, res);
    check("illegal_rsp", 32'(res), 32'({1'b0, 4'h0, 1'b0, 1'b0, 1'b1}));
    @(posedge clk); #1;
    check("illegal_cnt0", 32'(cnt0), 32'(11));

    // Reset while a req1 xor sits in EXEC
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, OP_XOR, 4'hA, 4'h5);
    n = 0;
    do begin @(negedge clk); n++; end while (!req1_ready && n < 20);
    if (!req1_ready) check("xor_grant_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    check("exec_busy", 32'({busy, rsp_valid}), 32'({1'b1, 1'b0}));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out, rsp_cout, rsp_v, rsp_err, busy}), 32'(0));
    check("async_reset_cnt", 32'({cnt1, cnt0}), 32'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_rsp_after_reset", 32'({rsp_valid, busy, cnt1}), 32'(0));
    stream(1, OP_ADD, 4'h2, 4'h3, OP_XOR, 4'hA, 4'h5, first_id, g0, g1);
    check("first_grant_after_reset", 32'(first_id), 32'(0));

    // Saturation of the narrow counter
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      do_cmd(1'b0, OP_ADD, 4'h1, 4'h1, 0, res);
      check("sat_rsp", 32'(res), 32'({1'b0, 4'h2, 1'b0, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    check("sat_cnt0_w2", 32'(s_cnt0), 32'(3));
    check("sat_cnt0_w8", 32'(cnt0), 32'(6));
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
